// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and types for the memory/writeback stage.
package riscv_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mw_state_t;

  typedef enum logic [1:0] {
    EXC_LOAD_MISALIGN  = 2'd0,
    EXC_STORE_MISALIGN = 2'd1,
    EXC_ACCESS_TIMEOUT = 2'd2
  } exc_cause_t;

  // Bytes are always aligned, halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic addr_aligned(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~addr[0];
      default: return (addr == 2'b00);
    endcase
  endfunction

  // Set/clear CSR forms skip the CSR write when rs1/uimm is zero.
  function automatic logic csr_is_set_clear(input logic [2:0] funct3);
    return (funct3 == F3_CSRRS) || (funct3 == F3_CSRRC) ||
           (funct3 == F3_CSRRSI) || (funct3 == F3_CSRRCI);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed lane out of a loaded word and sign/zero-extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Shift the addressed byte/halfword down to bit 0, then extend by load type.
  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data = {24'h000000, shifted[7:0]};
      F3_LHU:  data = {16'h0000, shifted[15:0]};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mw_stage_lsu.sv
// Memory/writeback stage: register-file and CSR writeback, loads/stores over a
// req/ack port, misaligned and ack-timeout exceptions.
module mw_stage_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] ir_in,
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] wd_in,
  input  logic [XLEN-1:0] csr_data_in,
  input  logic [XLEN-1:0] csr_addr_in,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            exc_valid,
  output logic [1:0]      exc_cause,
  output logic [XLEN-1:0] exc_pc
);

  localparam int               CNT_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam bit               TIMEOUT_EN = (ACK_TIMEOUT > 0);

  mw_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [2:0]  funct3;
  logic        is_load;
  logic        is_store;
  logic        aligned;
  logic [3:0]  store_be;
  logic [31:0] store_data;
  logic [31:0] load_data;

  logic            dmem_req_d;
  logic            dmem_we_d;
  logic [XLEN-1:0] dmem_addr_d;
  logic [3:0]      dmem_be_d;
  logic [XLEN-1:0] dmem_wdata_d;
  logic            rf_we_d;
  logic [4:0]      rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_d;
  logic            csr_we_d;
  logic [11:0]     csr_waddr_d;
  logic [XLEN-1:0] csr_wdata_d;
  logic            exc_valid_d;
  exc_cause_t      exc_cause_d;
  logic [XLEN-1:0] exc_pc_d;

  logic unused_bits;
  assign unused_bits = ^{ir_in[31:20], csr_addr_in[31:12]};

  assign opcode = ir_in[6:0];
  assign rd     = ir_in[11:7];
  assign funct3 = ir_in[14:12];
  assign rs1    = ir_in[19:15];

  lsu_load_align u_load_align (
    .rdata  (dmem_rdata),
    .addr   (alu_in[1:0]),
    .funct3 (funct3),
    .data   (load_data)
  );

  // Decode memory ops, alignment, store lanes and the combinational stall.
  always_comb begin
    is_load  = (opcode == LOAD);
    is_store = (opcode == STORE);
    aligned  = addr_aligned(funct3, alu_in[1:0]);
    case (funct3)
      F3_SB: begin
        store_be   = 4'b0001 << alu_in[1:0];
        store_data = {4{wd_in[7:0]}};
      end
      F3_SH: begin
        store_be   = 4'b0011 << alu_in[1:0];
        store_data = {2{wd_in[15:0]}};
      end
      default: begin
        store_be   = 4'hF;
        store_data = wd_in;
      end
    endcase
    stall_out = (state == ACCESS) || ((state == IDLE) && (is_load || is_store) && aligned);
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state;
    cnt_d        = '0;
    dmem_req_d   = dmem_req;
    dmem_we_d    = dmem_we;
    dmem_addr_d  = dmem_addr;
    dmem_be_d    = dmem_be;
    dmem_wdata_d = dmem_wdata;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr;
    rf_wdata_d   = rf_wdata;
    csr_we_d     = 1'b0;
    csr_waddr_d  = csr_waddr;
    csr_wdata_d  = csr_wdata;
    exc_valid_d  = 1'b0;
    exc_cause_d  = exc_cause_t'(exc_cause);
    exc_pc_d     = exc_pc;

    case (state)
      IDLE: begin
        if (is_load || is_store) begin
          if (aligned) begin
            state_d      = ACCESS;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_store;
            dmem_addr_d  = {alu_in[XLEN-1:2], 2'b00};
            dmem_be_d    = is_store ? store_be : 4'h0;
            dmem_wdata_d = is_store ? store_data : '0;
          end else begin
            exc_valid_d = 1'b1;
            exc_cause_d = is_load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
            exc_pc_d    = pc_in;
          end
        end else begin
          case (opcode)
            OP, OP_IMM, LUI, AUIPC: begin
              rf_we_d    = (rd != 5'd0);
              rf_waddr_d = rd;
              rf_wdata_d = alu_in;
            end
            JAL, JALR: begin
              rf_we_d    = (rd != 5'd0);
              rf_waddr_d = rd;
              rf_wdata_d = pc_in + 32'd4;
            end
            SYSTEM: begin
              if (funct3 != 3'b000) begin
                rf_we_d     = (rd != 5'd0);
                rf_waddr_d  = rd;
                rf_wdata_d  = csr_data_in;
                csr_we_d    = !(csr_is_set_clear(funct3) && (rs1 == 5'd0));
                csr_waddr_d = csr_addr_in[11:0];
                csr_wdata_d = alu_in;
              end
            end
            default: ;
          endcase
        end
      end

      ACCESS: begin
        if (dmem_ack) begin
          state_d    = DONE;
          dmem_req_d = 1'b0;
          if (!dmem_we) begin
            rf_we_d    = (rd != 5'd0);
            rf_waddr_d = rd;
            rf_wdata_d = load_data;
          end
        end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
          state_d     = DONE;
          dmem_req_d  = 1'b0;
          exc_valid_d = 1'b1;
          exc_cause_d = EXC_ACCESS_TIMEOUT;
          exc_pc_d    = pc_in;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, timeout counter and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'h0;
      dmem_wdata <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= '0;
      csr_we     <= 1'b0;
      csr_waddr  <= 12'd0;
      csr_wdata  <= '0;
      exc_valid  <= 1'b0;
      exc_cause  <= 2'd0;
      exc_pc     <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
      dmem_addr  <= dmem_addr_d;
      dmem_be    <= dmem_be_d;
      dmem_wdata <= dmem_wdata_d;
      rf_we      <= rf_we_d;
      rf_waddr   <= rf_waddr_d;
      rf_wdata   <= rf_wdata_d;
      csr_we     <= csr_we_d;
      csr_waddr  <= csr_waddr_d;
      csr_wdata  <= csr_wdata_d;
      exc_valid  <= exc_valid_d;
      exc_cause  <= exc_cause_d;
      exc_pc     <= exc_pc_d;
    end
  end

endmodule

// File: tb/tb_mw_stage_lsu.sv
// Directed testbench for mw_stage_lsu with hand-computed expectations.
module tb_mw_stage_lsu;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in, ir_in, alu_in, wd_in, csr_data_in, csr_addr_in;
  logic        stall_out;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_pc;

  int checkCount = 0;
  int errorCount = 0;

  mw_stage_lsu #(.XLEN(32), .ACK_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .ir_in       (ir_in),
    .alu_in      (alu_in),
    .wd_in       (wd_in),
    .csr_data_in (csr_data_in),
    .csr_addr_in (csr_addr_in),
    .stall_out   (stall_out),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .csr_we      (csr_we),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause),
    .exc_pc      (exc_pc)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] alu,
                               input logic [31:0] wd, input logic [31:0] csrData, input logic [31:0] csrAddr);
    pc_in       = pc;
    ir_in       = ir;
    alu_in      = alu;
    wd_in       = wd;
    csr_data_in = csrData;
    csr_addr_in = csrAddr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed scenario sequence.
  initial begin
    rst        = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    applyStimulus(32'h0, NOP, 32'h0, 32'h0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();

    $display("[TB] reset state");
    checkOutput("rst_req", dmem_req, 0);
    checkOutput("rst_we", dmem_we, 0);
    checkOutput("rst_addr", dmem_addr, 0);
    checkOutput("rst_be", dmem_be, 0);
    checkOutput("rst_wdata", dmem_wdata, 0);
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_rf_waddr", rf_waddr, 0);
    checkOutput("rst_rf_wdata", rf_wdata, 0);
    checkOutput("rst_csr_we", csr_we, 0);
    checkOutput("rst_csr_waddr", csr_waddr, 0);
    checkOutput("rst_csr_wdata", csr_wdata, 0);
    checkOutput("rst_exc_valid", exc_valid, 0);
    checkOutput("rst_exc_cause", exc_cause, 0);
    checkOutput("rst_exc_pc", exc_pc, 0);
    checkOutput("rst_stall", stall_out, 0);
    rst = 1'b1;
    nextCycle();

    $display("[TB] T1 addi x5,x0,10");
    applyStimulus(32'h100, 32'h00A00293, 32'd10, 32'h0, 32'h0, 32'h0);
    #1 checkOutput("t1_stall_n", stall_out, 0);
    nextCycle();
    checkOutput("t1_rf_we", rf_we, 1);
    checkOutput("t1_rf_waddr", rf_waddr, 5);
    checkOutput("t1_rf_wdata", rf_wdata, 10);
    checkOutput("t1_csr_we", csr_we, 0);
    applyStimulus(32'h104, NOP, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 checkOutput("t1_stall_n1", stall_out, 0);
    nextCycle();
    checkOutput("t1_rf_we_n2", rf_we, 0);

    $display("[TB] T2 lb x6 at 0x1003");
    applyStimulus(32'h104, 32'h00000303, 32'h1003, 32'h0, 32'h0, 32'h0);
    #1 checkOutput("t2_stall_n", stall_out, 1);
    nextCycle();
    checkOutput("t2_req_n1", dmem_req, 1);
    checkOutput("t2_we", dmem_we, 0);
    checkOutput("t2_addr", dmem_addr, 32'h1000);
    checkOutput("t2_be", dmem_be, 0);
    checkOutput("t2_stall_n1", stall_out, 1);
    checkOutput("t2_rf_we_n1", rf_we, 0);
    nextCycle();
    checkOutput("t2_req_n2", dmem_req, 1);
    checkOutput("t2_stall_n2", stall_out, 1);
    nextCycle();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h80FFFF00;
    #1 checkOutput("t2_stall_n3", stall_out, 1);
    checkOutput("t2_req_n3", dmem_req, 1);
    nextCycle();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    checkOutput("t2_req_n4", dmem_req, 0);
    checkOutput("t2_rf_we_n4", rf_we, 1);
    checkOutput("t2_rf_waddr", rf_waddr, 6);
    checkOutput("t2_rf_wdata", rf_wdata, 32'hFFFFFF80);
    checkOutput("t2_stall_done", stall_out, 0);
    nextCycle();
    checkOutput("t2_req_n5", dmem_req, 0);
    checkOutput("t2_rf_we_n5", rf_we, 0);
    applyStimulus(32'h108, NOP, 32'h0, 32'h0, 32'h0, 32'h0);
    nextCycle();

    $display("[TB] T3 sh at 0x2002");
    applyStimulus(32'h108, 32'h00001023, 32'h2002, 32'h1234ABCD, 32'h0, 32'h0);
    #1 checkOutput("t3_stall_n", stall_out, 1);
    nextCycle();
    checkOutput("t3_req", dmem_req, 1);
    checkOutput("t3_we", dmem_we, 1);
    checkOutput("t3_addr", dmem_addr, 32'h2000);
    checkOutput("t3_be", dmem_be, 4'b1100);
    checkOutput("t3_wdata", dmem_wdata, 32'hABCDABCD);
    nextCycle();
    checkOutput("t3_req_hold", dmem_req, 1);
    checkOutput("t3_be_hold", dmem_be, 4'b1100);
    checkOutput("t3_wdata_hold", dmem_wdata, 32'hABCDABCD);
    dmem_ack = 1'b1;
    nextCycle();
    dmem_ack = 1'b0;
    checkOutput("t3_req_drop", dmem_req, 0);
    checkOutput("t3_rf_we", rf_we, 0);
    checkOutput("t3_stall_done", stall_out, 0);
    nextCycle();
    applyStimulus(32'h10C, NOP, 32'h0, 32'h0, 32'h0, 32'h0);
    nextCycle();

    $display("[TB] sb at 0x3001 with single-cycle ack");
    applyStimulus(32'h10C, 32'h00000023, 32'h3001, 32'h000000EF, 32'h0, 32'h0);
    nextCycle();
    checkOutput("sb_req", dmem_req, 1);
    checkOutput("sb_addr", dmem_addr, 32'h3000);
    checkOutput("sb_be", dmem_be, 4'b0010);
    checkOutput("sb_wdata", dmem_wdata, 32'hEFEFEFEF);
    dmem_ack = 1'b1;
    nextCycle();
    dmem_ack = 1'b0;
    checkOutput("sb_req_drop", dmem_req, 0);
    checkOutput("sb_stall_done", stall_out, 0);
    nextCycle();
    applyStimulus(32'h110, NOP, 32'h0, 32'h0, 32'h0, 32'h0);
    nextCycle();

    $display("[TB] T4 misaligned lw and sh");
    applyStimulus(32'h200, 32'h00002403, 32'h2001, 32'h0, 32'h0, 32'h0);
    #1 checkOutput("t4_stall", stall_out, 0);
    nextCycle();
    checkOutput("t4_exc_valid", exc_valid, 1);
    checkOutput("t4_exc_cause", exc_cause, 0);
    checkOutput("t4_exc_pc", exc_pc, 32'h200);
    checkOutput("t4_req", dmem_req, 0);
    checkOutput("t4_rf_we", rf_we, 0);
    applyStimulus(32'h204, 32'h00001023, 32'h2003, 32'h0, 32'h0, 32'h0);
    #1 checkOutput("sh_mis_stall", stall_out, 0);
    nextCycle();
    checkOutput("sh_mis_exc_valid", exc_valid, 1);
    checkOutput("sh_mis_exc_cause", exc_cause, 1);
    checkOutput("sh_mis_exc_pc", exc_pc, 32'h204);
    checkOutput("sh_mis_req", dmem_req, 0);
    applyStimulus(32'h208, NOP, 32'h0, 32'h0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("t4_exc_pulse_end", exc_valid, 0);

    $display("[TB] T5 lw timeout");
    applyStimulus(32'h300, 32'h00002483, 32'h4000, 32'h0, 32'h0, 32'h0);
    #1 checkOutput("t5_stall_n", stall_out, 1);
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      checkOutput($sformatf("t5_req_n%0d", i), dmem_req, 1);
      checkOutput($sformatf("t5_exc_n%0d", i), exc_valid, 0);
    end
    nextCycle();
    checkOutput("t5_req_n5", dmem_req, 0);
    checkOutput("t5_exc_valid", exc_valid, 1);
    checkOutput("t5_exc_cause", exc_cause, 2);
    checkOutput("t5_exc_pc", exc_pc, 32'h300);
    checkOutput("t5_rf_we", rf_we, 0);
    checkOutput("t5_stall_done", stall_out, 0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    nextCycle();
    applyStimulus(32'h304, NOP, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("t5_late_exc", exc_valid, 0);
    checkOutput("t5_late_rf_we", rf_we, 0);
    checkOutput("t5_late_req", dmem_req, 0);
    nextCycle();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    checkOutput("t5_idle_req", dmem_req, 0);
    checkOutput("t5_idle_rf_we", rf_we, 0);

    $display("[TB] T6 csr and jump writebacks");
    applyStimulus(32'h400, 32'h300093F3, 32'h22, 32'h0, 32'h11, 32'h300);
    nextCycle();
    checkOutput("csrrw_rf_we", rf_we, 1);
    checkOutput("csrrw_rf_waddr", rf_waddr, 7);
    checkOutput("csrrw_rf_wdata", rf_wdata, 32'h11);
    checkOutput("csrrw_csr_we", csr_we, 1);
    checkOutput("csrrw_csr_waddr", csr_waddr, 12'h300);
    checkOutput("csrrw_csr_wdata", csr_wdata, 32'h22);
    applyStimulus(32'h404, 32'h300023F3, 32'h33, 32'h0, 32'h44, 32'h305);
    nextCycle();
    checkOutput("csrrs0_rf_we", rf_we, 1);
    checkOutput("csrrs0_rf_wdata", rf_wdata, 32'h44);
    checkOutput("csrrs0_csr_we", csr_we, 0);
    applyStimulus(32'h408, 32'h000000EF, 32'h999, 32'h0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("jal_rf_we", rf_we, 1);
    checkOutput("jal_rf_waddr", rf_waddr, 1);
    checkOutput("jal_rf_wdata", rf_wdata, 32'h40C);
    checkOutput("jal_csr_we", csr_we, 0);
    applyStimulus(32'h40C, 32'h00500013, 32'h5, 32'h0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("addi_x0_rf_we", rf_we, 0);

    $display("[TB] reset during access");
    applyStimulus(32'h500, 32'h00002503, 32'h5000, 32'h0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("rma_req_n1", dmem_req, 1);
    rst        = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12345678;
    nextCycle();
    checkOutput("rma_req", dmem_req, 0);
    checkOutput("rma_rf_we", rf_we, 0);
    checkOutput("rma_exc", exc_valid, 0);
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    applyStimulus(32'h504, NOP, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 checkOutput("rma_idle_stall", stall_out, 0);
    nextCycle();
    checkOutput("rma_after_req", dmem_req, 0);
    checkOutput("rma_after_rf_we", rf_we, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
